instr_mem_fetch: RTL and testbench

- Parametrised, synchronous-read instruction memory for the CPU fetch stage.
- Generalises the fixed 8x32 combinational memory: configurable word width, depth and address width.
- Adds a valid/ready fetch handshake with a registered response, a program-load write port, out-of-range detection, and an accepted-fetch counter.
- Sits between the PC/fetch unit and the decode stage.

---
 rtl/instr_mem_fetch.sv | 100 ++++++++++
 tb/tb_instr_mem_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_fetch.sv
// Synchronous-read instruction memory for the fetch stage: valid/ready fetch port
// with a one-entry registered response, program-load write port and fetch counter.
module instr_mem_fetch #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DEPTH      = 16,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_err,
   input  logic                  resp_ready,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_err,
   output logic [CNT_WIDTH-1:0]  fetch_count
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                  resp_err_q, resp_err_d;
   logic                  load_err_q, load_err_d;
   logic [CNT_WIDTH-1:0]  fetch_count_q, fetch_count_d;

   logic             accept;
   logic             req_in_range;
   logic             load_in_range;
   logic [IDX_W-1:0] req_idx;
   logic [IDX_W-1:0] load_idx;

   assign req_in_range  = ({1'b0, req_addr} < DEPTH_W);
   assign load_in_range = ({1'b0, load_addr} < DEPTH_W);
   // Index bits are only used when the full address is in range, so no aliasing.
   assign req_idx       = req_addr[IDX_W-1:0];
   assign load_idx      = load_addr[IDX_W-1:0];

   assign req_ready = !resp_valid_q || resp_ready;
   assign accept    = req_valid && req_ready;

   always_comb begin
      resp_valid_d  = resp_valid_q;
      resp_data_d   = resp_data_q;
      resp_err_d    = resp_err_q;
      fetch_count_d = fetch_count_q;
      load_err_d    = load_en && !load_in_range;
      if (accept) begin
         resp_valid_d = 1'b1;
         resp_data_d  = req_in_range ? mem_q[req_idx] : NOP_WORD;
         resp_err_d   = !req_in_range;
         if (fetch_count_q != {CNT_WIDTH{1'b1}}) begin
            fetch_count_d = fetch_count_q + 1'b1;
         end
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_q  <= 1'b0;
         resp_data_q   <= '0;
         resp_err_q    <= 1'b0;
         load_err_q    <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         resp_valid_q  <= resp_valid_d;
         resp_data_q   <= resp_data_d;
         resp_err_q    <= resp_err_d;
         load_err_q    <= load_err_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   // Array is not reset; the read above samples the old word on a same-address write.
   always_ff @(posedge clk) begin
      if (load_en && load_in_range) begin
         mem_q[load_idx] <= load_data;
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_data   = resp_data_q;
   assign resp_err    = resp_err_q;
   assign load_err    = load_err_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch; a second instance with a 4-bit counter
// shares all inputs to exercise counter saturation.
module tb_instr_mem_fetch;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic [7:0]  req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        resp_ready;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [31:0] load_data;
   logic        load_err;
   logic [15:0] fetch_count;

   logic        req_ready2;
   logic        resp_valid2;
   logic [31:0] resp_data2;
   logic        resp_err2;
   logic        load_err2;
   logic [3:0]  fetch_count2;

   int n_tests = 0;
   int n_fail  = 0;

   instr_mem_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .resp_ready(resp_ready),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .load_err(load_err), .fetch_count(fetch_count)
   );

   instr_mem_fetch #(.CNT_WIDTH(4)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready2),
      .resp_valid(resp_valid2), .resp_data(resp_data2), .resp_err(resp_err2),
      .resp_ready(resp_ready),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .load_err(load_err2), .fetch_count(fetch_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_of(input int i);
      return (i == 0) ? 32'hA000_000A : 32'(i) * 32'h1000_0011;
   endfunction

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      tick(); tick();
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_load_err", load_err, 0);
      check("rst_fetch_count", fetch_count, 0);
      rst_n = 1'b1;

      // program words 0..7
      for (int i = 0; i < 8; i++) begin
         load_en = 1'b1; load_addr = 8'(i); load_data = word_of(i);
         tick();
      end
      load_en = 1'b0;
      check("inrange_load_err", load_err, 0);
      check("no_fetch_count", fetch_count, 0);

      // reset then fetch
      req_valid = 1'b1; req_addr = 8'd1;
      tick();
      check("f1_valid", resp_valid, 1);
      check("f1_data", resp_data, 32'h1000_0011);
      check("f1_err", resp_err, 0);
      check("f1_count", fetch_count, 1);
      req_valid = 1'b0;
      tick();
      check("drain_valid", resp_valid, 0);
      check("drain_data_hold", resp_data, 32'h1000_0011);

      // stall and hold
      req_valid = 1'b1; req_addr = 8'd2; resp_ready = 1'b0;
      tick();
      check("f2_data", resp_data, 32'h2000_0022);
      req_addr = 8'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_ready", req_ready, 0);
         tick();
         check("stall_data", resp_data, 32'h2000_0022);
         check("stall_count", fetch_count, 2);
      end
      resp_ready = 1'b1;
      #1;
      check("unstall_ready", req_ready, 1);
      tick();
      check("f3_data", resp_data, 32'h3000_0033);
      check("f3_count", fetch_count, 3);

      // streaming 0..7
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1; req_addr = 8'(i);
         tick();
         check("stream_valid", resp_valid, 1);
         check("stream_data", resp_data, word_of(i));
      end
      check("stream_count", fetch_count, 11);

      // out of range fetch
      req_addr = 8'd20;
      tick();
      check("oor_data", resp_data, 32'h0);
      check("oor_err", resp_err, 1);
      check("oor_count", fetch_count, 12);
      req_valid = 1'b0;
      load_en = 1'b1; load_addr = 8'd16; load_data = 32'hFFFF_FFFF;
      tick();
      check("oor_load_err", load_err, 1);
      load_en = 1'b0;
      tick();
      check("oor_load_err_pulse", load_err, 0);
      req_valid = 1'b1; req_addr = 8'd0;
      tick();
      check("addr0_unchanged", resp_data, 32'hA000_000A);
      check("addr0_err", resp_err, 0);

      // same-address collision
      load_en = 1'b1; load_addr = 8'd5; load_data = 32'hDEAD_BEEF; req_addr = 8'd5;
      tick();
      check("collide_old", resp_data, 32'h5000_0055);
      load_en = 1'b0;
      tick();
      check("collide_new", resp_data, 32'hDEAD_BEEF);
      check("collide_count", fetch_count, 15);

      // held response immune to load
      req_valid = 1'b0; resp_ready = 1'b0;
      load_en = 1'b1; load_addr = 8'd5; load_data = 32'h1234_5678;
      tick();
      load_en = 1'b0;
      check("held_vs_load", resp_data, 32'hDEAD_BEEF);
      check("held_valid", resp_valid, 1);
      resp_ready = 1'b1;
      tick();

      // async reset with a response held
      req_valid = 1'b1; req_addr = 8'd7; resp_ready = 1'b0;
      tick();
      check("pre_rst_valid", resp_valid, 1);
      check("pre_rst_count", fetch_count, 16);
      check("sat_count_16", fetch_count2, 15);
      #2 rst_n = 1'b0;
      #1;
      check("async_valid", resp_valid, 0);
      check("async_count", fetch_count, 0);
      check("async_data", resp_data, 0);
      tick();
      req_valid = 1'b0; resp_ready = 1'b1;
      rst_n = 1'b1;
      tick();
      check("no_ghost_resp", resp_valid, 0);
      req_valid = 1'b1; req_addr = 8'd3;
      tick();
      check("post_rst_data", resp_data, 32'h3000_0033);
      check("post_rst_count", fetch_count, 1);

      // saturation
      for (int i = 0; i < 20; i++) begin
         req_addr = 8'(i % 8);
         tick();
      end
      req_valid = 1'b0;
      check("count_21", fetch_count, 21);
      check("sat_count", fetch_count2, 15);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
